// File: rtl/memory_pkg.sv
// Shared types for the memory-access stage: pipeline registers, data bus
// request/response, access-size encoding and the stage FSM states.
package memory_pkg;

  typedef logic [63:0] word_t;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef logic [7:0]  strobe_t;
  typedef logic [4:0]  creg_addr_t;

  // Access size, encoded exactly as instr[13:12]
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_JUMP   = 3'd4
  } op_t;

  typedef struct packed {
    op_t  op;
    logic regwrite;
  } control_t;

  typedef struct packed {
    logic       valid;
    u64         pc;
    u32         instr;
    control_t   ctl;
    creg_addr_t dst;
    word_t      rd2;
    word_t      result;
  } excute_data_t;

  typedef struct packed {
    logic       valid;
    u64         pc;
    u32         instr;
    control_t   ctl;
    creg_addr_t dst;
    word_t      result;
    logic       misalign;
  } memory_data_t;

  typedef struct packed {
    logic    valid;
    u64      addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } mem_state_t;

  // An access is aligned when the low address bits below its size are zero
  function automatic logic is_misaligned(input logic [2:0] off, input msize_t sz);
    case (sz)
      MSIZE1:  return 1'b0;
      MSIZE2:  return off[0];
      MSIZE4:  return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/memory_if.sv
// Data bus between the memory stage (master) and the data memory (slave).
interface memory_if;
  import memory_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/memory_memfmt.sv
// Byte-lane formatting for the data bus: store lane placement and strobe,
// load lane extraction with sign/zero extension. Purely combinational.
module memory_memfmt
  import memory_pkg::*;
(
  input  logic [2:0] i_st_off,
  input  msize_t     i_st_size,
  input  word_t      i_st_rd2,
  output strobe_t    o_st_strobe,
  output word_t      o_st_data,
  input  logic [2:0] i_ld_off,
  input  msize_t     i_ld_size,
  input  logic       i_ld_unsigned,
  input  word_t      i_ld_raw,
  output word_t      o_ld_data
);

  strobe_t w_base;
  word_t   w_shifted;

  // Store side: strobe mask for the size, moved up to the addressed lane
  always_comb begin
    case (i_st_size)
      MSIZE1:  w_base = 8'h01;
      MSIZE2:  w_base = 8'h03;
      MSIZE4:  w_base = 8'h0F;
      default: w_base = 8'hFF;
    endcase
  end

  assign o_st_strobe = w_base << i_st_off;
  assign o_st_data   = i_st_rd2 << {i_st_off, 3'b000};

  assign w_shifted = i_ld_raw >> {i_ld_off, 3'b000};

  // Load side: truncate the shifted word to the size, then extend
  always_comb begin
    case (i_ld_size)
      MSIZE1:  o_ld_data = i_ld_unsigned ? {56'd0, w_shifted[7:0]}
                                         : {{56{w_shifted[7]}}, w_shifted[7:0]};
      MSIZE2:  o_ld_data = i_ld_unsigned ? {48'd0, w_shifted[15:0]}
                                         : {{48{w_shifted[15]}}, w_shifted[15:0]};
      MSIZE4:  o_ld_data = i_ld_unsigned ? {32'd0, w_shifted[31:0]}
                                         : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/memory.sv
// Memory-access stage: issues one data-bus transaction per aligned load or
// store, stalls execute while it is outstanding and registers the completed
// instruction for writeback.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transaction; aligned mem op is latched into the request
// ST_REQ  | request on the bus, held stable until data_ok
module memory
  import memory_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  excute_data_t dataE,
  output memory_data_t dataM,
  memory_if.master     dbus,
  output logic         stopm
);

  mem_state_t   r_state;
  mem_state_t   w_state_next;
  dbus_req_t    r_req;
  logic         r_is_load;
  logic         r_ld_unsigned;
  memory_data_t r_dataM;
  memory_data_t w_dataM_next;

  logic    w_is_load;
  logic    w_is_store;
  logic    w_memop;
  logic    w_mis;
  logic    w_issue;
  logic    w_data_ok;
  msize_t  w_size;
  strobe_t w_st_strobe;
  word_t   w_st_data;
  word_t   w_ld_data;
  logic    w_unused_addr_ok;

  assign w_is_load  = dataE.valid && (dataE.ctl.op == OP_LOAD);
  assign w_is_store = dataE.valid && (dataE.ctl.op == OP_STORE);
  assign w_memop    = w_is_load || w_is_store;
  assign w_size     = msize_t'(dataE.instr[13:12]);
  assign w_mis      = is_misaligned(dataE.result[2:0], w_size);
  assign w_issue    = (r_state == ST_IDLE) && w_memop && !w_mis;
  assign w_data_ok  = dbus.dresp.data_ok;

  // Acceptance is irrelevant here; only data_ok ends a transaction
  assign w_unused_addr_ok = dbus.dresp.addr_ok;

  memory_memfmt u_fmt (
    .i_st_off      (dataE.result[2:0]),
    .i_st_size     (w_size),
    .i_st_rd2      (dataE.rd2),
    .o_st_strobe   (w_st_strobe),
    .o_st_data     (w_st_data),
    .i_ld_off      (r_req.addr[2:0]),
    .i_ld_size     (r_req.size),
    .i_ld_unsigned (r_ld_unsigned),
    .i_ld_raw      (dbus.dresp.data),
    .o_ld_data     (w_ld_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and stall; stall drops in the completing cycle so execute
  // advances on the same edge that dataM is written
  always_comb begin
    w_state_next = r_state;
    stopm        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_next = ST_REQ;
          stopm        = 1'b1;
        end
      end
      ST_REQ: begin
        if (w_data_ok) w_state_next = ST_IDLE;
        else           stopm        = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request registers: captured once on issue, frozen until data_ok
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req         <= '0;
      r_is_load     <= 1'b0;
      r_ld_unsigned <= 1'b0;
    end else if (w_issue) begin
      r_req.valid   <= 1'b1;
      r_req.addr    <= dataE.result;
      r_req.size    <= w_size;
      r_req.strobe  <= w_is_store ? w_st_strobe : '0;
      r_req.data    <= w_st_data;
      r_is_load     <= w_is_load;
      r_ld_unsigned <= dataE.instr[14];
    end else if ((r_state == ST_REQ) && w_data_ok) begin
      r_req.valid   <= 1'b0;
    end
  end

  assign dbus.dreq = r_req;

  // Writeback record; execute is held during REQ so dataE still describes
  // the instruction being completed
  always_comb begin
    w_dataM_next       = '0;
    w_dataM_next.pc    = dataE.pc;
    w_dataM_next.instr = dataE.instr;
    w_dataM_next.ctl   = dataE.ctl;
    w_dataM_next.dst   = dataE.dst;
    case (r_state)
      ST_IDLE: begin
        if (dataE.valid && !w_memop) begin
          w_dataM_next.valid  = 1'b1;
          w_dataM_next.result = dataE.result;
        end else if (w_memop && w_mis) begin
          w_dataM_next.valid    = 1'b1;
          w_dataM_next.misalign = 1'b1;
          w_dataM_next.result   = dataE.result;
        end
      end
      ST_REQ: begin
        if (w_data_ok) begin
          w_dataM_next.valid  = 1'b1;
          w_dataM_next.result = r_is_load ? w_ld_data : r_req.addr;
        end
      end
      default: ;
    endcase
  end

  // dataM register
  always_ff @(posedge clk) begin
    if (!reset) r_dataM <= '0;
    else        r_dataM <= w_dataM_next;
  end

  assign dataM = r_dataM;

endmodule
